// File: rtl/io_fifo_fl_if.sv
// Bundles the processor I/O port and the stream channels of io_fifo_fl.
// master = processor/stream environment, slave = the bridge itself.
interface io_fifo_fl_if #(
    parameter int NBW    = 23,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2
);
    localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

    logic                  proc_req_in;
    logic [AIW-1:0]        proc_addr_in;
    logic [NBW-1:0]        proc_io_in;
    logic                  proc_out_en;
    logic [AOW-1:0]        proc_addr_out;
    logic [NBW-1:0]        proc_io_out;
    logic                  itr;
    logic [NUIOIN*NBW-1:0] in_data;
    logic [NUIOIN-1:0]     in_valid;
    logic [NUIOIN-1:0]     in_ready;
    logic [NUIOOU*NBW-1:0] out_data;
    logic [NUIOOU-1:0]     out_valid;
    logic [NUIOOU-1:0]     out_ready;
    logic [NUIOIN-1:0]     underflow;
    logic [NUIOOU-1:0]     overflow;

    modport master (
        output proc_req_in, proc_addr_in, proc_out_en, proc_addr_out, proc_io_out,
        output in_data, in_valid, out_ready,
        input  proc_io_in, itr, in_ready, out_data, out_valid, underflow, overflow
    );

    modport slave (
        input  proc_req_in, proc_addr_in, proc_out_en, proc_addr_out, proc_io_out,
        input  in_data, in_valid, out_ready,
        output proc_io_in, itr, in_ready, out_data, out_valid, underflow, overflow
    );
endinterface

// File: rtl/io_fifo_fl.sv
// Buffered I/O bridge for proc_fl: per-channel FWFT FIFOs between the processor
// single-word port and valid/ready streams, plus an input fill-level interrupt.
module io_fifo_fl #(
    parameter int NBMANT = 16,
    parameter int NBEXPO = 6,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 4,
    parameter int ITRLVL = 2
) (
    input logic         clk,
    input logic         rst,
    io_fifo_fl_if.slave bus
);
    localparam int NBW = NBMANT + NBEXPO + 1;
    localparam int PW  = $clog2(FDEPTH);
    localparam int CW  = $clog2(FDEPTH + 1);
    localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
    localparam logic [CW-1:0] FULL = CW'(FDEPTH);
    localparam logic [CW-1:0] LVL  = CW'(ITRLVL);

    logic                  rdy_en;
    logic                  any_hi;
    logic                  any_hi_p1;
    logic [NUIOIN-1:0]     underflow_q;
    logic [NUIOOU-1:0]     overflow_q;

    logic [NUIOIN-1:0]     rd_sel;
    logic [NUIOIN-1:0]     ipush;
    logic [NUIOIN-1:0]     ipop;
    logic [NUIOIN-1:0]     inonempty;
    logic [NUIOIN-1:0]     ifull;
    logic [NUIOIN-1:0]     ihi;
    logic [NUIOIN-1:0]     unf_set;
    logic [NBW-1:0]        ihead [NUIOIN];

    logic [NUIOOU-1:0]     wr_sel;
    logic [NUIOOU-1:0]     opush;
    logic [NUIOOU-1:0]     opop;
    logic [NUIOOU-1:0]     ononempty;
    logic [NUIOOU-1:0]     ofull;
    logic [NUIOOU-1:0]     ovf_set;
    logic [NBW-1:0]        ohead [NUIOOU];

    logic [NBW-1:0]        io_rd;
    logic [NUIOOU*NBW-1:0] od;

    // Out-of-range addresses match no channel, so they read 0 and write nothing.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            rd_sel[k] = (bus.proc_addr_in == AIW'(k));
        end
    end

    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NUIOOU; k++) begin
            wr_sel[k] = (bus.proc_addr_out == AOW'(k));
        end
    end

    for (genvar k = 0; k < NUIOIN; k++) begin : g_in
        logic [NBW-1:0] mem [FDEPTH];
        logic [PW-1:0]  wp;
        logic [PW-1:0]  rp;
        logic [CW-1:0]  cnt;

        assign ipush[k]     = bus.in_valid[k] & bus.in_ready[k];
        assign ipop[k]      = bus.proc_req_in & rd_sel[k] & inonempty[k];
        assign unf_set[k]   = bus.proc_req_in & rd_sel[k] & ~inonempty[k];
        assign inonempty[k] = (cnt != '0);
        assign ifull[k]     = (cnt == FULL);
        assign ihi[k]       = (cnt >= LVL);
        assign ihead[k]     = mem[rp];

        always_ff @(posedge clk) begin
            if (ipush[k]) begin
                mem[wp] <= bus.in_data[k*NBW +: NBW];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (ipush[k]) wp <= wp + PW'(1);
                if (ipop[k])  rp <= rp + PW'(1);
                case ({ipush[k], ipop[k]})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // A processor write to a full FIFO is dropped even if the stream pops it this cycle.
    for (genvar k = 0; k < NUIOOU; k++) begin : g_out
        logic [NBW-1:0] mem [FDEPTH];
        logic [PW-1:0]  wp;
        logic [PW-1:0]  rp;
        logic [CW-1:0]  cnt;

        assign opush[k]     = bus.proc_out_en & wr_sel[k] & ~ofull[k];
        assign ovf_set[k]   = bus.proc_out_en & wr_sel[k] & ofull[k];
        assign opop[k]      = ononempty[k] & bus.out_ready[k];
        assign ononempty[k] = (cnt != '0);
        assign ofull[k]     = (cnt == FULL);
        assign ohead[k]     = mem[rp];

        always_ff @(posedge clk) begin
            if (opush[k]) begin
                mem[wp] <= bus.proc_io_out;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (opush[k]) wp <= wp + PW'(1);
                if (opop[k])  rp <= rp + PW'(1);
                case ({opush[k], opop[k]})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    always_comb begin
        io_rd = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (rd_sel[k] && inonempty[k]) io_rd = ihead[k];
        end
    end

    // Empty channels present zero so unreset storage never leaks onto the bus.
    always_comb begin
        od = '0;
        for (int k = 0; k < NUIOOU; k++) begin
            od[k*NBW +: NBW] = ononempty[k] ? ohead[k] : '0;
        end
    end

    assign any_hi = |ihi;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_en      <= 1'b0;
            any_hi_p1   <= 1'b0;
            underflow_q <= '0;
            overflow_q  <= '0;
        end else begin
            rdy_en      <= 1'b1;
            any_hi_p1   <= any_hi;
            underflow_q <= underflow_q | unf_set;
            overflow_q  <= overflow_q | ovf_set;
        end
    end

    assign bus.proc_io_in = io_rd;
    assign bus.out_data   = od;
    assign bus.out_valid  = ononempty;
    assign bus.in_ready   = rdy_en ? ~ifull : '0;
    assign bus.itr        = any_hi & ~any_hi_p1;
    assign bus.underflow  = underflow_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_io_fifo_fl.sv
// Bench for io_fifo_fl: vector table, hand-written corner sequences and a
// randomized queue-model run on input ch1 / output ch0.
module tb_io_fifo_fl;
    localparam int NBW = 23;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_fifo_fl_if #(.NBW(NBW), .NUIOIN(2), .NUIOOU(2)) bus ();

    io_fifo_fl #(
        .NBMANT(16), .NBEXPO(6), .NUIOIN(2), .NUIOOU(2), .FDEPTH(4), .ITRLVL(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk;
    int n_fail;

    typedef struct {
        logic           req;
        logic           ain;
        logic           oen;
        logic           aout;
        logic [NBW-1:0] wdata;
        logic [1:0]     ivld;
        logic [NBW-1:0] id0;
        logic [NBW-1:0] id1;
        logic [1:0]     ordy;
        logic [NBW-1:0] e_io;
        logic [1:0]     e_irdy;
        logic [1:0]     e_ovld;
        logic [NBW-1:0] e_od0;
        logic [NBW-1:0] e_od1;
        logic           e_itr;
        logic [1:0]     e_unf;
        logic [1:0]     e_ovf;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.proc_req_in   = 1'b0;
        bus.proc_addr_in  = '0;
        bus.proc_out_en   = 1'b0;
        bus.proc_addr_out = '0;
        bus.proc_io_out   = '0;
        bus.in_valid      = '0;
        bus.in_data       = '0;
        bus.out_ready     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [NBW-1:0] qin[$];
    logic [NBW-1:0] qout[$];

    initial begin
        int  isent, irecv, osent, orecv, cyc;
        bit  prev_hi, hi, wr, pushed, popped;

        n_chk  = 0;
        n_fail = 0;

        // field order: req ain oen aout wdata ivld id0 id1 ordy | io irdy ovld od0 od1 itr unf ovf
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 2'b10, 23'h0, 23'h12345A, 2'b00,
                   23'h0, 2'b11, 2'b00, 23'h0, 23'h0, 1'b0, 2'b00, 2'b00};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 23'h0, 2'b00, 23'h0, 23'h0, 2'b00,
                   23'h12345A, 2'b11, 2'b00, 23'h0, 23'h0, 1'b0, 2'b00, 2'b00};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 23'h0, 2'b00, 23'h0, 23'h0, 2'b00,
                   23'h0, 2'b11, 2'b00, 23'h0, 23'h0, 1'b0, 2'b00, 2'b00};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 23'h0, 2'b01, 23'h000222, 23'h0, 2'b00,
                   23'h0, 2'b11, 2'b00, 23'h0, 23'h0, 1'b0, 2'b00, 2'b00};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 23'h00ABCD, 2'b00, 23'h0, 23'h0, 2'b00,
                   23'h000222, 2'b11, 2'b00, 23'h0, 23'h0, 1'b0, 2'b01, 2'b00};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 23'h0, 2'b00, 23'h0, 23'h0, 2'b10,
                   23'h000222, 2'b11, 2'b10, 23'h0, 23'h00ABCD, 1'b0, 2'b01, 2'b00};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 2'b00, 23'h0, 23'h0, 2'b00,
                   23'h0, 2'b11, 2'b00, 23'h0, 23'h0, 1'b0, 2'b01, 2'b00};

        // Reset with in_valid held high
        idle();
        rst          = 1'b1;
        bus.in_valid = 2'b11;
        bus.in_data  = {23'h7FFFFF, 23'h7FFFFF};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_in_ready", i), bus.in_ready, 2'b00);
            chk($sformatf("rst%0d_out_valid", i), bus.out_valid, 2'b00);
            chk($sformatf("rst%0d_out_data", i), bus.out_data, '0);
            chk($sformatf("rst%0d_itr", i), bus.itr, 1'b0);
            chk($sformatf("rst%0d_io_in", i), bus.proc_io_in, '0);
            chk($sformatf("rst%0d_flags", i), {bus.underflow, bus.overflow}, 4'b0);
        end
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("rel_in_ready", bus.in_ready, 2'b11);
        tick();

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            idle();
            bus.proc_req_in   = tbl[i].req;
            bus.proc_addr_in  = tbl[i].ain;
            bus.proc_out_en   = tbl[i].oen;
            bus.proc_addr_out = tbl[i].aout;
            bus.proc_io_out   = tbl[i].wdata;
            bus.in_valid      = tbl[i].ivld;
            bus.in_data       = {tbl[i].id1, tbl[i].id0};
            bus.out_ready     = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_io", i), bus.proc_io_in, tbl[i].e_io);
            chk($sformatf("vec%0d_in_ready", i), bus.in_ready, tbl[i].e_irdy);
            chk($sformatf("vec%0d_out_valid", i), bus.out_valid, tbl[i].e_ovld);
            chk($sformatf("vec%0d_out_data", i), bus.out_data, {tbl[i].e_od1, tbl[i].e_od0});
            chk($sformatf("vec%0d_itr", i), bus.itr, tbl[i].e_itr);
            chk($sformatf("vec%0d_underflow", i), bus.underflow, tbl[i].e_unf);
            chk($sformatf("vec%0d_overflow", i), bus.overflow, tbl[i].e_ovf);
            tick();
        end

        // Five writes to output ch0 with out_ready low; the fifth must be dropped
        for (int i = 1; i <= 5; i++) begin
            idle();
            bus.proc_out_en   = 1'b1;
            bus.proc_addr_out = 1'b0;
            bus.proc_io_out   = NBW'(i);
            tick();
        end
        idle();
        bus.out_ready = 2'b01;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk($sformatf("ovf_drain%0d_valid", j), bus.out_valid[0], 1'b1);
            chk($sformatf("ovf_drain%0d_data", j), bus.out_data[NBW-1:0], NBW'(j));
            chk($sformatf("ovf_drain%0d_flag", j), bus.overflow, 2'b01);
            tick();
        end
        @(negedge clk);
        chk("ovf_empty_valid", bus.out_valid, 2'b00);
        chk("ovf_sticky", bus.overflow, 2'b01);
        chk("unf_sticky", bus.underflow, 2'b01);
        tick();

        // Interrupt: threshold crossing on ch0, no re-trigger above it, re-arm below it
        idle();
        bus.in_valid = 2'b01; bus.in_data = {23'h0, 23'h10};
        @(negedge clk); chk("itr_push1", bus.itr, 1'b0); tick();
        bus.in_data = {23'h0, 23'h11};
        @(negedge clk); chk("itr_push2", bus.itr, 1'b0); tick();
        bus.in_data = {23'h0, 23'h12};
        @(negedge clk); chk("itr_fire1", bus.itr, 1'b1); tick();
        idle();
        bus.proc_req_in = 1'b1; bus.proc_addr_in = 1'b0;
        @(negedge clk); chk("itr_third_push", bus.itr, 1'b0); chk("itr_rd1", bus.proc_io_in, 23'h10); tick();
        @(negedge clk); chk("itr_lvl2_quiet", bus.itr, 1'b0); chk("itr_rd2", bus.proc_io_in, 23'h11); tick();
        idle();
        bus.in_valid = 2'b01; bus.in_data = {23'h0, 23'h13};
        @(negedge clk); chk("itr_lvl1_quiet", bus.itr, 1'b0); tick();
        idle();
        @(negedge clk); chk("itr_fire2", bus.itr, 1'b1); tick();
        @(negedge clk); chk("itr_single", bus.itr, 1'b0); tick();

        // Reset mid-operation discards buffered words and clears flags
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("mid_rst_in_ready", bus.in_ready, 2'b00);
        chk("mid_rst_out_valid", bus.out_valid, 2'b00);
        chk("mid_rst_io_in", bus.proc_io_in, '0);
        chk("mid_rst_flags", {bus.underflow, bus.overflow}, 4'b0);
        chk("mid_rst_itr", bus.itr, 1'b0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_rel_in_ready", bus.in_ready, 2'b11);
        chk("mid_rel_io_in", bus.proc_io_in, '0);
        tick();

        // Random concurrent traffic: stream in ch1 -> processor, processor -> stream out ch0
        isent = 0; irecv = 0; osent = 0; orecv = 0; cyc = 0; prev_hi = 1'b0;
        while ((irecv < 20 || orecv < 20) && cyc < 2000) begin
            idle();
            bus.proc_addr_in = 1'b1;
            bus.proc_req_in  = (qin.size() != 0);
            if (isent < 20) begin
                bus.in_valid[1]           = 1'($urandom % 2);
                bus.in_data[2*NBW-1:NBW] = NBW'($urandom);
            end
            wr = (osent < 20) && ($urandom % 2 == 1) && (qout.size() < 4);
            bus.proc_out_en   = wr;
            bus.proc_addr_out = 1'b0;
            bus.proc_io_out   = NBW'($urandom);
            bus.out_ready[0]  = 1'($urandom % 2);
            @(negedge clk);
            hi = (qin.size() >= 2);
            chk("rnd_in_ready", bus.in_ready[1], qin.size() < 4);
            if (qin.size() != 0) chk("rnd_io_in", bus.proc_io_in, qin[0]);
            chk("rnd_itr", bus.itr, hi && !prev_hi);
            chk("rnd_out_valid", bus.out_valid[0], qout.size() != 0);
            if (qout.size() != 0) chk("rnd_out_data", bus.out_data[NBW-1:0], qout[0]);
            pushed = bus.in_valid[1] && (qin.size() < 4);
            popped = bus.out_ready[0] && (qout.size() != 0);
            if (qin.size() != 0) begin
                void'(qin.pop_front());
                irecv++;
            end
            if (pushed) begin
                qin.push_back(bus.in_data[2*NBW-1:NBW]);
                isent++;
            end
            if (popped) begin
                void'(qout.pop_front());
                orecv++;
            end
            if (wr) begin
                qout.push_back(bus.proc_io_out);
                osent++;
            end
            prev_hi = hi;
            tick();
            cyc++;
        end
        chk("rnd_completed_in_budget", cyc < 2000, 1'b1);
        @(negedge clk);
        chk("rnd_no_underflow", bus.underflow, 2'b00);
        chk("rnd_no_overflow", bus.overflow, 2'b00);
        chk("rnd_drained", bus.out_valid, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
